// File: rtl/wb_queue_pkg.sv
// Shared definitions for the write-back queue and the register file it feeds.
package wb_queue_pkg;

    localparam int NUM_REGS = 8;
    localparam int REGSEL_W = 3;
    localparam int DATA_W   = 16;

    // One queued write-back request at the default data width.
    typedef struct packed {
        logic [REGSEL_W-1:0] regsel;
        logic [DATA_W-1:0]   data;
    } wbq_entry_t;

    // Register select to one-hot register mask (also used by the regfile write decode).
    function automatic logic [NUM_REGS-1:0] regsel_onehot(input logic [REGSEL_W-1:0] sel);
        logic [NUM_REGS-1:0] m;
        m      = '0;
        m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wbq_mem.sv
// Entry storage for the write-back queue: two write ports, one read port,
// plus a flat view of all destination selects for the pending-write mask.
module wbq_mem
    import wb_queue_pkg::*;
#(
    parameter int width = DATA_W,
    parameter int depth = 4,
    localparam int PTR_W = $clog2(depth)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             we0_i,
    input  logic [PTR_W-1:0]                 waddr0_i,
    input  logic [REGSEL_W-1:0]              wsel0_i,
    input  logic [width-1:0]                 wdata0_i,
    input  logic                             we1_i,
    input  logic [PTR_W-1:0]                 waddr1_i,
    input  logic [REGSEL_W-1:0]              wsel1_i,
    input  logic [width-1:0]                 wdata1_i,
    input  logic [PTR_W-1:0]                 raddr_i,
    output logic [REGSEL_W-1:0]              rsel_o,
    output logic [width-1:0]                 rdata_o,
    output logic [depth-1:0][REGSEL_W-1:0]   sel_all_o
);

    logic [depth-1:0][REGSEL_W-1:0] sel_q;
    logic [depth-1:0][width-1:0]    data_q;

    // Entry array update; the two write addresses never coincide when both are enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < depth; i++) begin
                if (we0_i && (waddr0_i == PTR_W'(i))) begin
                    sel_q[i]  <= wsel0_i;
                    data_q[i] <= wdata0_i;
                end else if (we1_i && (waddr1_i == PTR_W'(i))) begin
                    sel_q[i]  <= wsel1_i;
                    data_q[i] <= wdata1_i;
                end
            end
        end
    end

    assign rsel_o    = sel_q[raddr_i];
    assign rdata_o   = data_q[raddr_i];
    assign sel_all_o = sel_q;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue merging ALU and MDU results onto the single register
// file write port, draining one entry per cycle in acceptance order.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int width = DATA_W,
    parameter int depth = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [REGSEL_W-1:0] alu_regsel,
    input  logic [width-1:0]    alu_data,
    output logic                alu_ready,
    input  logic                mdu_valid,
    input  logic [REGSEL_W-1:0] mdu_regsel,
    input  logic [width-1:0]    mdu_data,
    output logic                mdu_ready,
    output logic                write,
    output logic [REGSEL_W-1:0] writeregsel,
    output logic [width-1:0]    writedata,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                err
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]               count_q, count_d, free_s, acc_n_s;
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]               waddr1_s, offset_s;
    logic                           mdu_acc_s, alu_acc_s, pop_s;
    logic                           we0_s, we1_s;
    logic [REGSEL_W-1:0]            wsel0_s, head_sel_s, last_sel_q;
    logic [width-1:0]               wdata0_s, head_data_s, last_data_q;
    logic [depth-1:0][REGSEL_W-1:0] sel_all_s;
    logic [NUM_REGS-1:0]            pend_s;
    logic                           alu_wait_q, mdu_wait_q, err_q, err_d;

    // Readiness from registered occupancy only; a same-cycle pop never frees space.
    // The MDU wins the last free slot because its instruction is older.
    always_comb begin
        free_s    = CNT_W'(depth) - count_q;
        mdu_ready = (free_s >= CNT_W'(1));
        alu_ready = (free_s >= CNT_W'(2)) | ((free_s == CNT_W'(1)) & ~mdu_valid);
        mdu_acc_s = mdu_valid & mdu_ready;
        alu_acc_s = alu_valid & alu_ready;
        pop_s     = (count_q != '0);
        acc_n_s   = CNT_W'(mdu_acc_s) + CNT_W'(alu_acc_s);
    end

    // Write-port steering: MDU lands at wr_ptr so it drains ahead of a same-cycle ALU entry.
    always_comb begin
        we0_s    = mdu_acc_s | alu_acc_s;
        we1_s    = mdu_acc_s & alu_acc_s;
        waddr1_s = wr_ptr_q + PTR_W'(1);
        if (mdu_acc_s) begin
            wsel0_s  = mdu_regsel;
            wdata0_s = mdu_data;
        end else begin
            wsel0_s  = alu_regsel;
            wdata0_s = alu_data;
        end
    end

    // Pointer, occupancy and sticky-error next state.
    always_comb begin
        count_d  = count_q + acc_n_s - CNT_W'(pop_s);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
        wr_ptr_d = wr_ptr_q + PTR_W'(acc_n_s);
        err_d    = err_q | (alu_wait_q & ~alu_valid) | (mdu_wait_q & ~mdu_valid);
    end

    // Pending-write mask: OR of one-hot targets of every occupied slot.
    always_comb begin
        pend_s   = '0;
        offset_s = '0;
        for (int i = 0; i < depth; i++) begin
            offset_s = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, offset_s} < count_q) begin
                pend_s = pend_s | regsel_onehot(sel_all_s[i]);
            end else begin
                pend_s = pend_s;
            end
        end
    end

    // Queue state, last-driven write values and stalled-request tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            last_sel_q  <= '0;
            last_data_q <= '0;
            alu_wait_q  <= 1'b0;
            mdu_wait_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            alu_wait_q <= alu_valid & ~alu_ready;
            mdu_wait_q <= mdu_valid & ~mdu_ready;
            err_q      <= err_d;
            if (pop_s) begin
                last_sel_q  <= head_sel_s;
                last_data_q <= head_data_s;
            end
        end
    end

    wbq_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .we0_i     (we0_s),
        .waddr0_i  (wr_ptr_q),
        .wsel0_i   (wsel0_s),
        .wdata0_i  (wdata0_s),
        .we1_i     (we1_s),
        .waddr1_i  (waddr1_s),
        .wsel1_i   (alu_regsel),
        .wdata1_i  (alu_data),
        .raddr_i   (rd_ptr_q),
        .rsel_o    (head_sel_s),
        .rdata_o   (head_data_s),
        .sel_all_o (sel_all_s)
    );

    // When empty the select/data hold whatever was last presented.
    assign write       = pop_s;
    assign writeregsel = pop_s ? head_sel_s  : last_sel_q;
    assign writedata   = pop_s ? head_data_s : last_data_q;
    assign pend_mask   = pend_s;
    assign err         = err_q;

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue.
module tb_wb_queue;
    import wb_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mdu_valid;
    logic [2:0]  alu_regsel, mdu_regsel;
    logic [15:0] alu_data, mdu_data;
    logic        alu_ready, mdu_ready;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic [7:0]  pend_mask;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_queue #(.width(16), .depth(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_regsel (alu_regsel),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mdu_valid  (mdu_valid),
        .mdu_regsel (mdu_regsel),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .write      (write),
        .writeregsel(writeregsel),
        .writedata  (writedata),
        .pend_mask  (pend_mask),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [2:0] ms, input logic [15:0] md,
                         input logic av, input logic [2:0] as, input logic [15:0] ad);
        mdu_valid = mv; mdu_regsel = ms; mdu_data = md;
        alu_valid = av; alu_regsel = as; alu_data = ad;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_write", write, 1'b0);
        chk("rst_sel", writeregsel, 3'd0);
        chk("rst_data", writedata, 16'h0000);
        chk("rst_pend", pend_mask, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_mdu_ready", mdu_ready, 1'b1);

        // ALU alone
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        chk("alu_write", write, 1'b1);
        chk("alu_sel", writeregsel, 3'd3);
        chk("alu_data", writedata, 16'h1234);
        chk("alu_pend", pend_mask, 8'h08);
        tick();
        chk("alu_drained_write", write, 1'b0);
        chk("alu_drained_pend", pend_mask, 8'h00);
        chk("alu_hold_sel", writeregsel, 3'd3);
        chk("alu_hold_data", writedata, 16'h1234);
        chk("alu_err", err, 1'b0);

        // Simultaneous accept, same destination: MDU first
        drive(1'b1, 3'd5, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        chk("sim_write0", write, 1'b1);
        chk("sim_sel0", writeregsel, 3'd5);
        chk("sim_data0", writedata, 16'hAAAA);
        chk("sim_pend0", pend_mask, 8'h20);
        tick();
        chk("sim_write1", write, 1'b1);
        chk("sim_data1", writedata, 16'h5555);
        chk("sim_pend1", pend_mask, 8'h20);
        tick();
        chk("sim_write2", write, 1'b0);
        chk("sim_pend2", pend_mask, 8'h00);

        // Backpressure with scoreboard: 10 MDU + 10 ALU requests, valid held until accepted
        begin : backpressure
            wbq_entry_t q[$];
            wbq_entry_t e;
            int mn, an, cyc, fr;
            logic exp_mr, exp_ar, macc, aacc;
            logic [7:0] pm;
            mn = 0; an = 0; cyc = 0;
            while ((mn < 10 || an < 10 || q.size() != 0) && cyc < 80) begin
                drive(mn < 10, 3'(mn % 8), 16'hC000 + 16'(mn),
                      an < 10, 3'((an + 3) % 8), 16'hA000 + 16'(an));
                #1;
                fr     = 4 - q.size();
                exp_mr = (fr >= 1);
                exp_ar = (fr >= 2) || (fr == 1 && !mdu_valid);
                chk("bp_mdu_ready", mdu_ready, exp_mr);
                chk("bp_alu_ready", alu_ready, exp_ar);
                macc = mdu_valid && exp_mr;
                aacc = alu_valid && exp_ar;
                @(posedge clk);
                #1;
                if (q.size() != 0) void'(q.pop_front());
                if (macc) begin
                    e.regsel = mdu_regsel; e.data = mdu_data; q.push_back(e); mn++;
                end
                if (aacc) begin
                    e.regsel = alu_regsel; e.data = alu_data; q.push_back(e); an++;
                end
                cyc++;
                pm = '0;
                foreach (q[k]) pm = pm | regsel_onehot(q[k].regsel);
                chk("bp_write", write, q.size() != 0);
                if (q.size() != 0) begin
                    chk("bp_sel", writeregsel, q[0].regsel);
                    chk("bp_data", writedata, q[0].data);
                end
                chk("bp_pend", pend_mask, pm);
            end
            chk("bp_all_done", (mn == 10 && an == 10 && q.size() == 0), 1'b1);
            chk("bp_err", err, 1'b0);
        end

        // Priority at one free slot, then withdrawn ALU request
        drive(1'b1, 3'd1, 16'h0101, 1'b1, 3'd2, 16'h0202);
        tick();
        drive(1'b1, 3'd3, 16'h0303, 1'b1, 3'd4, 16'h0404);
        tick();
        chk("pri_sel", writeregsel, 3'd2);
        chk("pri_data", writedata, 16'h0202);
        chk("pri_pend", pend_mask, 8'h1C);
        drive(1'b1, 3'd5, 16'h0505, 1'b1, 3'd6, 16'h0606);
        #1;
        chk("pri_alu_ready_both", alu_ready, 1'b0);
        chk("pri_mdu_ready_both", mdu_ready, 1'b1);
        mdu_valid = 1'b0;
        #1;
        chk("pri_alu_ready_alone", alu_ready, 1'b1);
        mdu_valid = 1'b1;
        #1;
        tick();
        chk("pri_err_before", err, 1'b0);
        chk("pri_pend_after", pend_mask, 8'h38);
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        tick();
        chk("err_set", err, 1'b1);
        chk("err_head_sel", writeregsel, 3'd4);
        tick();
        chk("err_hold1", err, 1'b1);
        chk("err_head_mdu", writeregsel, 3'd5);
        tick();
        chk("err_hold2", err, 1'b1);
        chk("err_empty_write", write, 1'b0);

        // Reset mid-operation
        drive(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
        tick();
        drive(1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 16'h4444);
        tick();
        chk("mid_pend", pend_mask, 8'h1C);
        drive(1'b1, 3'd5, 16'h5555, 1'b1, 3'd6, 16'h6666);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        #1;
        chk("mid_write", write, 1'b0);
        chk("mid_pend_clr", pend_mask, 8'h00);
        chk("mid_err", err, 1'b0);
        chk("mid_sel", writeregsel, 3'd0);
        chk("mid_data", writedata, 16'h0000);
        chk("mid_alu_ready", alu_ready, 1'b1);
        chk("mid_mdu_ready", mdu_ready, 1'b1);
        drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h7777);
        tick();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
        chk("post_write", write, 1'b1);
        chk("post_sel", writeregsel, 3'd7);
        chk("post_data", writedata, 16'h7777);
        chk("post_pend", pend_mask, 8'h80);
        tick();
        chk("post_drained", write, 1'b0);
        chk("post_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
